// File: rtl/ulight_fifo_timecode_pkg.sv
// Timecode capture shared definitions.
// Register addresses plus STATUS and IRQ_MASK bit positions.
package ulight_fifo_timecode_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_LAST   = 2'd3;

  localparam int DATA_VALID = 8;

  localparam int ST_OVF   = 8;
  localparam int ST_EMPTY = 9;
  localparam int ST_FULL  = 10;
  localparam int ST_SEQ   = 11;

  localparam int MSK_NE  = 0;
  localparam int MSK_OVF = 1;
  localparam int MSK_SEQ = 2;

endpackage

// File: rtl/ulight_fifo_timecode_rx_fifo.sv
// Show-ahead synchronous FIFO for received timecodes.
// Push while full succeeds only when a pop happens in the same cycle.
module ulight_fifo_timecode_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [4:0]   count,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [4:0]    cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == 5'd0);
  assign full    = (cnt == DEPTH_C);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ulight_fifo_timecode_rx_capture.sv
// SpaceWire timecode capture with Avalon-MM register access.
// Define TIMECODE_RX_SEQ_CHECK_EN to enable timecode sequence checking.
module ulight_fifo_timecode_rx_capture
  import ulight_fifo_timecode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic [7:0]  time_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

`ifdef TIMECODE_RX_SEQ_CHECK_EN
  localparam logic [2:0] MASK_WR = 3'b111;
`else
  localparam logic [2:0] MASK_WR = 3'b011;
`endif

  logic [7:0] head;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       data_rd;
  logic       pop;
  logic       push;
  logic       wr;
  logic       wr_status;
  logic       overflow;
  logic       seq_err;
  logic [2:0] mask;
  logic [7:0] last_time;
  logic [7:0] tick_cnt;
  logic       unused_bits;

  assign data_rd   = chipselect & ~read_n & (address == ADDR_DATA);
  assign pop       = data_rd & ~empty;
  assign push      = tick_in & (~full | pop);
  assign wr        = chipselect & ~write_n;
  assign wr_status = wr & (address == ADDR_STATUS);

  assign unused_bits = ^{writedata[31:12], writedata[11],
                         writedata[10:9], writedata[7:3]};

  ulight_fifo_timecode_rx_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (time_in),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Sticky overflow, mask, last timecode and tick counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      mask      <= '0;
      last_time <= '0;
      tick_cnt  <= '0;
    end else begin
      if (tick_in & full & ~pop)
        overflow <= 1'b1;
      else if (wr_status & writedata[ST_OVF])
        overflow <= 1'b0;
      if (wr & (address == ADDR_MASK))
        mask <= writedata[2:0] & MASK_WR;
      if (tick_in)
        last_time <= time_in;
      if (wr & (address == ADDR_LAST))
        tick_cnt <= {7'd0, tick_in};
      else if (tick_in)
        tick_cnt <= tick_cnt + 8'd1;
    end
  end

`ifdef TIMECODE_RX_SEQ_CHECK_EN
  logic       have_prev;
  logic [5:0] next_tc;

  assign next_tc = last_time[5:0] + 6'd1;

  // Flag any timecode that does not follow its predecessor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_prev <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      if (tick_in) have_prev <= 1'b1;
      if (tick_in & have_prev & (time_in[5:0] != next_tc))
        seq_err <= 1'b1;
      else if (wr_status & writedata[ST_SEQ])
        seq_err <= 1'b0;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  // Interrupt is a registered OR of the enabled sources.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else irq <= (mask[MSK_NE] & ~empty)
              | (mask[MSK_OVF] & overflow)
              | (mask[MSK_SEQ] & seq_err);
  end

  // Zero-wait-state register read mux.
  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA: begin
        if (!empty) begin
          readdata[7:0]        = head;
          readdata[DATA_VALID] = 1'b1;
        end
      end
      ADDR_STATUS: begin
        readdata[4:0]     = count;
        readdata[ST_OVF]  = overflow;
        readdata[ST_EMPTY] = empty;
        readdata[ST_FULL] = full;
        readdata[ST_SEQ]  = seq_err;
      end
      ADDR_MASK: readdata[2:0] = mask;
      ADDR_LAST: readdata[15:0] = {tick_cnt, last_time};
      default: readdata = '0;
    endcase
  end

endmodule
